// File: rtl/rx_gain_spi_mc_if.sv
// rx_gain_spi_mc_if: command handshake bundle for the receive-gain serial loader
interface rx_gain_spi_mc_if #(
    parameter int WORD_W = 16,
    parameter int NCH    = 4
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [WORD_W-1:0]       cmd_data;
    logic [$clog2(NCH)-1:0]  cmd_ch;
    logic                    cmd_bcast;
    modport master (output cmd_valid, cmd_data, cmd_ch, cmd_bcast, input cmd_ready);
    modport slave  (input cmd_valid, cmd_data, cmd_ch, cmd_bcast, output cmd_ready);
endinterface

// File: rtl/rx_gain_spi_mc.sv
// rx_gain_spi_mc: shifts a gain word to serial attenuators, then pulses the selected latch enable(s)
module rx_gain_spi_mc #(
    parameter int WORD_W    = 16,
    parameter int DIV       = 32,
    parameter int LE_CYCLES = 32,
    parameter int NCH       = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic               clk,
    input  logic               rst,
    rx_gain_spi_mc_if.slave    cmd,
    output logic               gain_si_o,
    output logic               gain_clk_o,
    output logic [NCH-1:0]     gain_le_o,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int CW = $clog2(NCH);
    localparam int PW = $clog2(2*DIV);
    localparam int BW = $clog2(WORD_W);
    localparam int LW = $clog2(LE_CYCLES+1);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
    state_t            state, state_n;
    logic [WORD_W-1:0] sr, sr_n;
    logic [PW-1:0]     ph, ph_n;
    logic [BW-1:0]     bc, bc_n;
    logic [LW-1:0]     lc, lc_n;
    logic [CW-1:0]     ch, ch_n;
    logic              bcast, bcast_n;
    logic              si_n, sclk_n, done_n, err_n;
    logic [NCH-1:0]    le_n;
    logic              accept, bad, bit_end;
    assign cmd.cmd_ready = state == IDLE;
    assign busy          = state != IDLE;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign bad           = !bcast && ({1'b0, ch} >= (CW+1)'(NCH));
    assign bit_end       = ph == PW'(2*DIV-1);
    // next-state and next-output logic; SI advances on the edge that drops SCLK
    always_comb begin
        state_n = state;
        sr_n    = sr;
        ph_n    = ph;
        bc_n    = bc;
        lc_n    = lc;
        ch_n    = ch;
        bcast_n = bcast;
        si_n    = gain_si_o;
        sclk_n  = gain_clk_o;
        le_n    = gain_le_o;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_n = SHIFT;
                sr_n    = cmd.cmd_data;
                ch_n    = cmd.cmd_ch;
                bcast_n = cmd.cmd_bcast;
                ph_n    = '0;
                bc_n    = '0;
                sclk_n  = 1'b0;
                si_n    = (MSB_FIRST != 0) ? cmd.cmd_data[WORD_W-1] : cmd.cmd_data[0];
            end
            SHIFT: begin
                ph_n = bit_end ? '0 : ph + 1'b1;
                if (ph == PW'(DIV-1)) sclk_n = 1'b1;
                if (bit_end) begin
                    sclk_n = 1'b0;
                    bc_n   = bc + 1'b1;
                    sr_n   = (MSB_FIRST != 0) ? sr << 1 : sr >> 1;
                    si_n   = (MSB_FIRST != 0) ? sr[WORD_W-2] : sr[1];
                    if (bc == BW'(WORD_W-1)) begin
                        state_n = LATCH;
                        si_n    = 1'b0;
                        lc_n    = '0;
                        le_n    = bcast ? '1 : bad ? '0 : NCH'(1) << ch;
                    end
                end
            end
            LATCH: begin
                lc_n = lc + 1'b1;
                if (lc == LW'(LE_CYCLES-1)) begin
                    state_n = IDLE;
                    le_n    = '0;
                    done_n  = 1'b1;
                    err_n   = bad;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // state and registered outputs; reset abandons any transfer immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            ph         <= '0;
            bc         <= '0;
            lc         <= '0;
            ch         <= '0;
            bcast      <= 1'b0;
            gain_si_o  <= 1'b0;
            gain_clk_o <= 1'b0;
            gain_le_o  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            ph         <= ph_n;
            bc         <= bc_n;
            lc         <= lc_n;
            ch         <= ch_n;
            bcast      <= bcast_n;
            gain_si_o  <= si_n;
            gain_clk_o <= sclk_n;
            gain_le_o  <= le_n;
            done       <= done_n;
            err        <= err_n;
        end
    end
endmodule

// File: tb/tb_rx_gain_spi_mc.sv
// tb_rx_gain_spi_mc: runs LSB-first, MSB-first and three-channel loaders in lock-step against a cycle model
module tb_rx_gain_spi_mc;
    localparam int W = 16, D = 2, L = 3, S = 2*D*W;
    logic clk = 1'b0, rst = 1'b1;
    logic valid = 1'b0, bcast = 1'b0;
    logic [W-1:0] data = '0;
    logic [1:0] ch = '0;
    logic [2:0] si, sclk, busy, done, err, rdy;
    logic [3:0] le0, le1;
    logic [2:0] le2;
    int n_assert = 0, n_fail = 0;
    rx_gain_spi_mc_if #(.WORD_W(W), .NCH(4)) if0 (), if1 ();
    rx_gain_spi_mc_if #(.WORD_W(W), .NCH(3)) if2 ();
    assign if0.cmd_valid = valid;
    assign if1.cmd_valid = valid;
    assign if2.cmd_valid = valid;
    assign if0.cmd_data = data;
    assign if1.cmd_data = data;
    assign if2.cmd_data = data;
    assign if0.cmd_ch = ch;
    assign if1.cmd_ch = ch;
    assign if2.cmd_ch = ch;
    assign if0.cmd_bcast = bcast;
    assign if1.cmd_bcast = bcast;
    assign if2.cmd_bcast = bcast;
    assign rdy = {if2.cmd_ready, if1.cmd_ready, if0.cmd_ready};
    rx_gain_spi_mc #(.WORD_W(W), .DIV(D), .LE_CYCLES(L), .NCH(4), .MSB_FIRST(0)) u0 (
        .clk(clk), .rst(rst), .cmd(if0.slave), .gain_si_o(si[0]), .gain_clk_o(sclk[0]),
        .gain_le_o(le0), .busy(busy[0]), .done(done[0]), .err(err[0]));
    rx_gain_spi_mc #(.WORD_W(W), .DIV(D), .LE_CYCLES(L), .NCH(4), .MSB_FIRST(1)) u1 (
        .clk(clk), .rst(rst), .cmd(if1.slave), .gain_si_o(si[1]), .gain_clk_o(sclk[1]),
        .gain_le_o(le1), .busy(busy[1]), .done(done[1]), .err(err[1]));
    rx_gain_spi_mc #(.WORD_W(W), .DIV(D), .LE_CYCLES(L), .NCH(3), .MSB_FIRST(0)) u2 (
        .clk(clk), .rst(rst), .cmd(if2.slave), .gain_si_o(si[2]), .gain_clk_o(sclk[2]),
        .gain_le_o(le2), .busy(busy[2]), .done(done[2]), .err(err[2]));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, " si"}, si, 3'b000);
        chk({tag, " sclk"}, sclk, 3'b000);
        chk({tag, " le"}, {le2, le1, le0}, 11'h0);
        chk({tag, " busy"}, busy, 3'b000);
        chk({tag, " done"}, done, 3'b000);
        chk({tag, " err"}, err, 3'b000);
        chk({tag, " ready"}, rdy, 3'b111);
    endtask
    // expected outputs k cycles after the accepting edge, derived from the transfer timeline
    task automatic chk_cycle(input int k, input logic [W-1:0] d, input logic [1:0] c, input logic b);
        logic [2:0] e_si, e_sclk;
        logic [3:0] m4;
        logic [2:0] m3;
        logic e_busy, e_done, e_err2;
        int i, p;
        e_si = '0; e_sclk = '0; m4 = '0; m3 = '0;
        e_busy = 1'b1; e_done = 1'b0; e_err2 = 1'b0;
        if (k <= S) begin
            i = (k-1) / (2*D);
            p = (k-1) % (2*D);
            e_sclk = (p >= D) ? 3'b111 : 3'b000;
            e_si = {d[i], d[W-1-i], d[i]};
        end else if (k <= S+L) begin
            m4 = b ? 4'hF : 4'(1) << c;
            m3 = b ? 3'h7 : (c < 2'd3) ? 3'(1) << c : 3'h0;
        end else begin
            e_busy = 1'b0;
            e_done = 1'b1;
            e_err2 = !b && c == 2'd3;
        end
        chk($sformatf("si k%0d", k), si, e_si);
        chk($sformatf("sclk k%0d", k), sclk, e_sclk);
        chk($sformatf("busy k%0d", k), busy, {3{e_busy}});
        chk($sformatf("ready k%0d", k), rdy, {3{!e_busy}});
        chk($sformatf("done k%0d", k), done, {3{e_done}});
        chk($sformatf("err k%0d", k), err, {e_err2, 2'b00});
        chk($sformatf("le4 k%0d", k), {le1, le0}, {m4, m4});
        chk($sformatf("le3 k%0d", k), le2, m3);
    endtask
    task automatic run_cmd(input logic [W-1:0] d, input logic [1:0] c, input logic b, input bit keep);
        data = d; ch = c; bcast = b; valid = 1'b1;
        chk("ready before accept", rdy, 3'b111);
        @(posedge clk);
        for (int k = 1; k <= S+L+1; k++) begin
            #1;
            chk_cycle(k, d, c, b);
            if (k == 1) begin
                data = W'($urandom);
                ch = 2'($urandom);
                bcast = 1'($urandom);
                valid = keep;
            end
            if (k <= S+L) @(posedge clk);
        end
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("post reset");
        run_cmd(16'h00A5, 2'd2, 1'b0, 1'b0);
        run_cmd(16'h00A5, 2'd2, 1'b1, 1'b0);
        run_cmd(16'h3C5A, 2'd3, 1'b0, 1'b0);
        run_cmd(W'($urandom), 2'($urandom), 1'b0, 1'b1);
        run_cmd(W'($urandom), 2'($urandom), 1'b0, 1'b0);
        data = 16'hBEEF; ch = 2'd1; bcast = 1'b0; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (26) @(posedge clk);
        #1;
        chk("sclk 7th rise", sclk, 3'b111);
        rst = 1'b1;
        #1;
        chk_idle("mid reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            chk_idle("after abort");
        end
        run_cmd(16'h1234, 2'd1, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++)
            run_cmd(W'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)));
        run_cmd(W'($urandom), 2'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_idle("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
